// File: rtl/rate_pulse_decoder_if.sv
// Bus for rate_pulse_decoder: control inputs toward the decoder and the
// registered measurement results back from it.
interface rate_pulse_decoder_if #(
   parameter int WIN_BITS = 16,
   parameter int ACC_BITS = WIN_BITS + 1
);
   logic                P_0;
   logic                Z;
   logic                CLR;
   logic [ACC_BITS-1:0] C_OUT;
   logic                VALID;
   logic                LOCK;
   logic [WIN_BITS-1:0] WCNT;

   modport master (output P_0, Z, CLR, input  C_OUT, VALID, LOCK, WCNT);
   modport slave  (input  P_0, Z, CLR, output C_OUT, VALID, LOCK, WCNT);
endinterface

// File: rtl/rate_pulse_decoder.sv
// Rate pulse decoder: counts Z pulses over windows of 2^WIN_BITS enabled
// cycles and publishes each window's count with a one-cycle VALID strobe.
// Windows run back-to-back; CLR restarts measurement from IDLE.
module rate_pulse_decoder #(
   parameter int WIN_BITS = 16,
   parameter int ACC_BITS = WIN_BITS + 1
) (
   input  logic               CK,
   input  logic               RN,
   rate_pulse_decoder_if.slave bus
);
   typedef enum logic {S_IDLE = 1'b0, S_MEASURE = 1'b1} state_t;

   localparam logic [WIN_BITS-1:0] WONE = {{(WIN_BITS-1){1'b0}}, 1'b1};

   logic [1:0]          r_rst_sync;
   logic                w_run;
   state_t              r_state,  w_state_nx;
   logic [WIN_BITS-1:0] r_wcnt,   w_wcnt_nx;
   logic [ACC_BITS-1:0] r_acc,    w_acc_nx;
   logic [ACC_BITS-1:0] r_cout,   w_cout_nx;
   logic                r_valid,  w_valid_nx;
   logic                r_lock,   w_lock_nx;
   logic [ACC_BITS-1:0] w_acc_inc;
   logic                w_final;

   // Async-assert / sync-release: state stays in reset through the release
   // edge and the following one, so no register moves on the release edge.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) r_rst_sync <= 2'b00;
      else     r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_run = r_rst_sync[1];

   assign w_acc_inc = r_acc + {{(ACC_BITS-1){1'b0}}, bus.Z};
   assign w_final   = (r_wcnt == {WIN_BITS{1'b1}});

   // Next-state and datapath update; CLR outranks P_0/Z, disabled cycles hold.
   always_comb begin
      w_state_nx = r_state;
      w_wcnt_nx  = r_wcnt;
      w_acc_nx   = r_acc;
      w_cout_nx  = r_cout;
      w_valid_nx = 1'b0;
      w_lock_nx  = r_lock;
      if (bus.CLR) begin
         w_state_nx = S_IDLE;
         w_wcnt_nx  = '0;
         w_acc_nx   = '0;
         w_cout_nx  = '0;
         w_lock_nx  = 1'b0;
      end else if (bus.P_0) begin
         // IDLE's first enabled cycle is window position 0, same as MEASURE.
         w_state_nx = S_MEASURE;
         if (w_final) begin
            w_cout_nx  = w_acc_inc;
            w_valid_nx = 1'b1;
            w_lock_nx  = 1'b1;
            w_acc_nx   = '0;
            w_wcnt_nx  = '0;
         end else begin
            w_acc_nx   = w_acc_inc;
            w_wcnt_nx  = r_wcnt + WONE;
         end
      end
   end

   // State and output registers; outputs come straight from these flops.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_acc   <= '0;
         r_cout  <= '0;
         r_valid <= 1'b0;
         r_lock  <= 1'b0;
      end else if (!w_run) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_acc   <= '0;
         r_cout  <= '0;
         r_valid <= 1'b0;
         r_lock  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_wcnt  <= w_wcnt_nx;
         r_acc   <= w_acc_nx;
         r_cout  <= w_cout_nx;
         r_valid <= w_valid_nx;
         r_lock  <= w_lock_nx;
      end
   end

   assign bus.C_OUT = r_cout;
   assign bus.VALID = r_valid;
   assign bus.LOCK  = r_lock;
   assign bus.WCNT  = r_wcnt;
endmodule

// File: tb/tb_rate_pulse_decoder.sv
// Scoreboard bench for rate_pulse_decoder with a 16-cycle window
// (WIN_BITS=4). Stimulus pushes the expected count and strobe cycle at each
// window's final enabled cycle; a negedge monitor pops and compares on VALID.
module tb_rate_pulse_decoder;
   localparam int WB = 4;
   localparam int AB = 5;

   typedef struct {
      int cout;
      int cyc;
   } exp_t;

   logic CK = 1'b0;
   logic RN = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   rate_pulse_decoder_if #(.WIN_BITS(WB), .ACC_BITS(AB)) bus ();

   rate_pulse_decoder #(.WIN_BITS(WB), .ACC_BITS(AB)) dut (
      .CK (CK),
      .RN (RN),
      .bus(bus)
   );

   always #5 CK = ~CK;
   always @(posedge CK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge CK) begin
      if (bus.VALID === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe got c_out=%0d want no strobe", bus.C_OUT);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("strobe_c_out", int'(bus.C_OUT), e.cout);
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_lock", int'(bus.LOCK), 1);
         end
      end
   end

   // One clock of stimulus; fin marks the window's final enabled cycle.
   task automatic step(input logic p, input logic z, input logic c,
                       input bit fin, input int exp_cout);
      exp_t e;
      bus.P_0 = p;
      bus.Z   = z;
      bus.CLR = c;
      if (fin) begin
         e.cout = exp_cout;
         e.cyc  = cyc + 1;
         q.push_back(e);
      end
      @(posedge CK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      bus.P_0 = 1'b0;
      bus.Z   = 1'b0;
      bus.CLR = 1'b0;

      // Reset state
      #2;
      chk("rst_c_out", int'(bus.C_OUT), 0);
      chk("rst_valid", int'(bus.VALID), 0);
      chk("rst_lock",  int'(bus.LOCK),  0);
      chk("rst_wcnt",  int'(bus.WCNT),  0);
      @(posedge CK); #1;
      RN = 1'b1;
      idle(3);
      chk("post_rst_wcnt", int'(bus.WCNT), 0);

      // Full window of pulses: maximum count 2^WB, no wrap
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, i == 15, 16);
      chk("full_lock", int'(bus.LOCK), 1);
      chk("full_wcnt", int'(bus.WCNT), 0);

      // Alternating Z starting at 1, two back-to-back windows, 16 cycles apart
      for (int i = 0; i < 32; i++) step(1'b1, ~i[0], 1'b0, (i % 16) == 15, 8);

      // P_0 toggling with Z=1 throughout: disabled-cycle pulses ignored
      for (int i = 0; i < 32; i++) step(~i[0], 1'b1, 1'b0, i == 30, 16);
      idle(4);
      chk("hold_c_out", int'(bus.C_OUT), 16);
      chk("hold_valid", int'(bus.VALID), 0);
      chk("hold_wcnt",  int'(bus.WCNT),  0);

      // Sparse pattern: pulses at positions 0,3,6,9,12,15
      for (int i = 0; i < 16; i++) step(1'b1, (i % 3) == 0, 1'b0, i == 15, 6);

      // CLR mid-window at WCNT=10, then a zero-pulse window
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("pre_clr_wcnt", int'(bus.WCNT), 10);
      chk("pre_clr_lock", int'(bus.LOCK), 1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 0);
      chk("clr_wcnt",  int'(bus.WCNT),  0);
      chk("clr_lock",  int'(bus.LOCK),  0);
      chk("clr_c_out", int'(bus.C_OUT), 0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, i == 15, 0);

      // Window with 9 pulses to leave a nonzero C_OUT behind
      for (int i = 0; i < 16; i++) step(1'b1, i < 9, 1'b0, i == 15, 9);
      idle(2);
      chk("nine_c_out", int'(bus.C_OUT), 9);

      // CLR on the final cycle suppresses the strobe and the update
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("pre_final_wcnt", int'(bus.WCNT), 15);
      step(1'b1, 1'b1, 1'b1, 1'b0, 0);
      chk("clr_final_valid", int'(bus.VALID), 0);
      chk("clr_final_c_out", int'(bus.C_OUT), 0);
      chk("clr_final_lock",  int'(bus.LOCK),  0);
      chk("clr_final_wcnt",  int'(bus.WCNT),  0);
      idle(2);

      // Window that sets C_OUT/LOCK before the reset test
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, i == 15, 16);
      // Async reset mid-window with P_0=1, Z=1
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("pre_arst_wcnt", int'(bus.WCNT), 7);
      RN = 1'b0;
      #1;
      chk("arst_c_out", int'(bus.C_OUT), 0);
      chk("arst_valid", int'(bus.VALID), 0);
      chk("arst_lock",  int'(bus.LOCK),  0);
      chk("arst_wcnt",  int'(bus.WCNT),  0);
      @(posedge CK); #1;
      bus.P_0 = 1'b0;
      RN = 1'b1;
      idle(3);
      chk("arst_rel_wcnt", int'(bus.WCNT), 0);
      // Partial window was discarded: fresh window counts only its own pulses
      for (int i = 0; i < 16; i++) step(1'b1, i < 3, 1'b0, i == 15, 3);
      idle(4);

      chk("missing_strobes", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rate_pulse_decoder.md
RATE_PULSE_DECODER -- requirements
Module: rate_pulse_decoder

Interface
REQ-001 Parameter WIN_BITS, default 16, window-counter width; window length = 2^WIN_BITS enabled cycles.
REQ-002 Parameter ACC_BITS, default WIN_BITS+1 (17), pulse-accumulator/result width; SHALL hold 2^WIN_BITS without overflow.
REQ-003 CK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RN  input  1  reset, asynchronous assert, active-low.
REQ-005 P_0  input  1  step enable; only cycles with P_0=1 advance the window or count pulses.
REQ-006 Z  input  1  pulse stream from the rate multiplier, sampled synchronously.
REQ-007 CLR  input  1  synchronous clear/restart.
REQ-008 C_OUT  output  ACC_BITS  pulse count of the last completed window.
REQ-009 VALID  output  1  one-cycle strobe marking a new C_OUT.
REQ-010 LOCK  output  1  high once at least one window has completed since reset/CLR.
REQ-011 WCNT  output  WIN_BITS  current window position, for observation.

Function
REQ-012 The block SHALL have a two-state FSM: IDLE and MEASURE.
REQ-013 IDLE: WCNT=0, accumulator A=0; the first cycle with P_0=1 SHALL be counted as window position 0 and SHALL move the FSM to MEASURE.
REQ-014 MEASURE, P_0=1: WCNT SHALL increment by 1, wrapping modulo 2^WIN_BITS; A SHALL increment by 1 when Z=1.
REQ-015 MEASURE, P_0=0: WCNT, A and the FSM state SHALL hold; Z SHALL be ignored.
REQ-016 An enabled cycle with WCNT = 2^WIN_BITS-1 is the window's final cycle.
REQ-017 On that cycle the next registered values SHALL be: C_OUT = A + Z; VALID = 1; LOCK = 1; A = 0; WCNT = 0.
REQ-018 The FSM SHALL stay in MEASURE across window boundaries, so windows run back-to-back with no dead cycle.
REQ-019 VALID SHALL be high for exactly the one cycle after the final cycle and low otherwise.
REQ-020 C_OUT SHALL hold its value between VALID strobes.
REQ-021 Latency from the final enabled cycle to C_OUT/VALID visible SHALL be 1 clock.
REQ-022 A SHALL never wrap; its maximum value 2^WIN_BITS SHALL be representable.
REQ-023 CLR=1 SHALL take priority over P_0 and Z and, on the next edge, SHALL produce: FSM=IDLE; WCNT=0; A=0; C_OUT=0; VALID=0; LOCK=0.
REQ-024 CLR coinciding with a window's final cycle SHALL suppress that VALID strobe and that C_OUT update.
REQ-025 All outputs SHALL be direct register outputs; no combinational path from inputs to outputs.

Reset
REQ-026 RN=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE; WCNT=0; A=0; C_OUT=0; VALID=0; LOCK=0.
REQ-027 RN deasserted mid-window SHALL discard the partial window; the next window starts at the first P_0=1 after release.
REQ-028 Reset release SHALL be synchronized so that no state changes on the release edge itself.

Verification
REQ-029 RN pulsed low mid-operation, with P_0=1 and Z=1 -> all outputs 0 asynchronously; WCNT restarts from 0 after release.
REQ-030 P_0=1 and Z=1 for 65536 cycles -> VALID high for exactly one cycle after the last enabled cycle, C_OUT=17'h10000, LOCK=1.
REQ-031 P_0=1, Z alternating 1/0 starting at 1 -> C_OUT=32768 at each strobe; strobes exactly 65536 cycles apart.
REQ-032 P_0 toggling 1/0 and Z=1 on every cycle -> one strobe per 131072 cycles, C_OUT=65536 (Z during P_0=0 ignored).
REQ-033 CLR at WCNT=100, then P_0=1 and Z=0 -> next edge gives WCNT=0 and LOCK=0; next strobe comes 65536 enabled cycles later with C_OUT=0.
REQ-034 CLR asserted on a window's final cycle -> no VALID strobe; C_OUT=0; FSM=IDLE.
